// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One bit per pipeline-bank control; the datapath top level consumes the same bundle.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hazard_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs from the datapath and stall/flush controls back to it
interface pipeline_hazard_ctrl_if;
  logic [4:0] rs1D;
  logic [4:0] rs2D;
  logic [4:0] rdE;
  logic       regWriteE;
  logic       loadE;
  logic       pcSrcE;
  logic       mdStartE;
  logic       dmemReqM;
  logic       dmemReadyM;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       stallM;
  logic       flushD;
  logic       flushE;
  logic       flushM;
  logic       flushW;
  logic       busy;

  // master: the hazard controller; slave: the datapath it steers
  modport master (
    input  rs1D, rs2D, rdE, regWriteE, loadE, pcSrcE, mdStartE, dmemReqM, dmemReadyM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, busy
  );

  modport slave (
    output rs1D, rs2D, rdE, regWriteE, loadE, pcSrcE, mdStartE, dmemReqM, dmemReadyM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, busy
  );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and taken-branch detection
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs1_d_i,
  input  logic [4:0] rs2_d_i,
  input  logic [4:0] rd_e_i,
  input  logic       reg_write_e_i,
  input  logic       load_e_i,
  input  logic       pc_src_e_i,
  output logic       load_use_o,
  output logic       branch_o
);

  logic rd_match;

  assign rd_match   = (rd_e_i != REG_ZERO) && ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
  // A taken branch squashes the D instruction anyway, so it overrides the load-use stall.
  assign load_use_o = load_e_i & reg_write_e_i & rd_match & ~pc_src_e_i;
  assign branch_o   = pc_src_e_i;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline register banks
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.master hz
);

  ctrl_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               md_done_q, md_done_d;
  logic               load_use, branch, mem_stall, mul_div, lu_flush;
  hazard_ctrl_t       raw, ctrl;

  hazard_detect u_detect (
    .rs1_d_i       (hz.rs1D),
    .rs2_d_i       (hz.rs2D),
    .rd_e_i        (hz.rdE),
    .reg_write_e_i (hz.regWriteE),
    .load_e_i      (hz.loadE),
    .pc_src_e_i    (hz.pcSrcE),
    .load_use_o    (load_use),
    .branch_o      (branch)
  );

  assign mem_stall = hz.dmemReqM & ~hz.dmemReadyM;
  assign mul_div   = hz.mdStartE & ~md_done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_done_d = 1'b0;
    lu_flush  = 1'b0;
    raw       = '0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          {raw.stall_f, raw.stall_d, raw.stall_e, raw.stall_m, raw.flush_w} = 5'b11111;
          state_d = MEM_WAIT;
        end else if (mul_div) begin
          {raw.stall_f, raw.stall_d, raw.stall_e, raw.flush_m} = 4'b1111;
          cnt_d   = CNT_W'(MD_LATENCY - 1);
          state_d = MD_WAIT;
        end else if (load_use) begin
          {raw.stall_f, raw.stall_d} = 2'b11;
          lu_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        {raw.stall_f, raw.stall_d, raw.stall_e, raw.flush_m} = 4'b1111;
        cnt_d = cnt_q - CNT_W'(1);
        // md_done blocks the still-resident mul/div from retriggering on the release cycle
        if (cnt_q == CNT_W'(1)) begin
          state_d   = RUN;
          md_done_d = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.dmemReadyM) begin
          {raw.stall_f, raw.stall_d, raw.stall_e, raw.stall_m, raw.flush_w} = 5'b11111;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // A held bank must keep its contents; a pending branch flushes once the stall lifts.
    raw.flush_d = branch & ~raw.stall_d;
    raw.flush_e = (branch | lu_flush) & ~raw.stall_e;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_done_q <= md_done_d;
    end
  end

  assign ctrl      = reset ? '0 : raw;
  assign hz.stallF = ctrl.stall_f;
  assign hz.stallD = ctrl.stall_d;
  assign hz.stallE = ctrl.stall_e;
  assign hz.stallM = ctrl.stall_m;
  assign hz.flushD = ctrl.flush_d;
  assign hz.flushE = ctrl.flush_e;
  assign hz.flushM = ctrl.flush_m;
  assign hz.flushW = ctrl.flush_w;
  assign hz.busy   = ~reset & (state_q != RUN);

endmodule
